// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-master sram-like arbiter, one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed data-first priority.
module sram_like_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        addr_ok,
  input  logic        data_ok
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_e;

  state_e state_q, state_d;
  logic   lock_q, lock_d;
  logic   lock_data_q, lock_data_d;
  logic   gnt_inst, gnt_data;
  logic   data_wins;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data_q, last_data_d;
  assign data_wins = !last_data_q;
`else
  assign data_wins = 1'b1;
`endif

  // A locked grant survives only while its owner keeps req high; otherwise arbitrate afresh.
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (rst && state_q == IDLE) begin
      if (lock_q && lock_data_q && data_req) begin
        gnt_data = 1'b1;
      end else if (lock_q && !lock_data_q && inst_req) begin
        gnt_inst = 1'b1;
      end else if (inst_req && data_req) begin
        gnt_data = data_wins;
        gnt_inst = !data_wins;
      end else begin
        gnt_inst = inst_req;
        gnt_data = data_req;
      end
    end
  end

  always_comb begin
    req          = gnt_inst | gnt_data;
    wr           = 1'b0;
    size         = 2'b00;
    addr         = 32'h0;
    wdata        = 32'h0;
    if (gnt_data) begin
      wr    = data_wr;
      size  = data_size;
      addr  = data_addr;
      wdata = data_wdata;
    end else if (gnt_inst) begin
      wr    = inst_wr;
      size  = inst_size;
      addr  = inst_addr;
      wdata = inst_wdata;
    end
    inst_addr_ok = gnt_inst & addr_ok;
    data_addr_ok = gnt_data & addr_ok;
    inst_data_ok = rst && state_q == WAIT_I && data_ok;
    data_data_ok = rst && state_q == WAIT_D && data_ok;
    inst_rdata   = inst_data_ok ? rdata : 32'h0;
    data_rdata   = data_data_ok ? rdata : 32'h0;
  end

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    lock_data_d = lock_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_inst || gnt_data) begin
          if (addr_ok) begin
            state_d = gnt_data ? WAIT_D : WAIT_I;
            lock_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_d = gnt_data;
`endif
          end else begin
            lock_d      = 1'b1;
            lock_data_d = gnt_data;
          end
        end else begin
          lock_d = 1'b0;
        end
      end
      WAIT_I, WAIT_D: begin
        if (data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      lock_q      <= 1'b0;
      lock_data_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      lock_data_q <= lock_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - scoreboard bench: directed scenarios plus random traffic.
module tb_sram_like_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata, addr, wdata, rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        req, wr, addr_ok, data_ok;

  sram_like_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        iaok, daok, idok, ddok;
  } cyc_t;
  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } rsp_t;

  cyc_t cyc_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Transaction-level reference: who owns the slave (0 none, 1 inst, 2 data) and who was served last.
  int m_state = 0;
  int m_owner = 0;
  int m_last  = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    addr_ok = 0; data_ok = 0; rdata = 0;
  endtask

  task automatic step(output int acc);
    cyc_t e;
    int   own;
    e = '{default: '0};
    acc = 0;
    own = 0;
    if (!rst) begin
      m_state = 0; m_owner = 0; m_last = 2;
    end else if (m_state == 0) begin
      if (m_owner == 1 && inst_req) own = 1;
      else if (m_owner == 2 && data_req) own = 2;
      else if (inst_req && data_req) own = (RR && m_last == 2) ? 1 : 2;
      else if (inst_req) own = 1;
      else if (data_req) own = 2;
      if (own == 1) begin
        e.req = 1; e.wr = inst_wr; e.size = inst_size; e.addr = inst_addr;
        e.wdata = inst_wdata; e.iaok = addr_ok;
      end else if (own == 2) begin
        e.req = 1; e.wr = data_wr; e.size = data_size; e.addr = data_addr;
        e.wdata = data_wdata; e.daok = addr_ok;
      end
      if (own != 0 && addr_ok) begin
        m_state = own; m_last = own; m_owner = 0; acc = own;
      end else begin
        m_owner = own;
      end
    end else if (data_ok) begin
      e.idok = (m_state == 1);
      e.ddok = (m_state == 2);
      rsp_q.push_back('{is_data: (m_state == 2), rdata: rdata});
      m_state = 0;
    end
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    cyc_t e;
    rsp_t r;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("req", {31'b0, req}, {31'b0, e.req});
      chk("wr", {31'b0, wr}, {31'b0, e.wr});
      chk("size", {30'b0, size}, {30'b0, e.size});
      chk("addr", addr, e.addr);
      chk("wdata", wdata, e.wdata);
      chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, e.iaok});
      chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, e.daok});
      chk("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, e.idok});
      chk("data_data_ok", {31'b0, data_data_ok}, {31'b0, e.ddok});
      if (inst_data_ok || data_data_ok) begin
        if (rsp_q.size() == 0) begin
          chk("spurious_data_ok", {31'b0, inst_data_ok | data_data_ok}, 32'h0);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_owner_is_data", {31'b0, data_data_ok}, {31'b0, r.is_data});
          if (inst_data_ok) chk("inst_rdata", inst_rdata, r.rdata);
          if (data_data_ok) chk("data_rdata", data_rdata, r.rdata);
        end
      end else if ((e.idok || e.ddok) && rsp_q.size() > 0) begin
        void'(rsp_q.pop_front());
      end
      if (!inst_data_ok) chk("inst_rdata_idle", inst_rdata, 32'h0);
      if (!data_data_ok) chk("data_rdata_idle", data_rdata, 32'h0);
    end
  end

  initial begin : stim
    int  acc;
    bit  i_act, d_act;
    zero_inputs();
    rst = 0;
    @(posedge clk); #1;
    rdata = 32'h12345678; data_ok = 1; inst_req = 1; addr_ok = 1;
    step(acc); step(acc);
    zero_inputs();
    rst = 1;

    // single inst read with 2-cycle data latency
    inst_req = 1; inst_addr = 32'hBFC00000; addr_ok = 1; step(acc);
    zero_inputs(); step(acc);
    data_ok = 1; rdata = 32'h3C080001; step(acc);
    zero_inputs(); step(acc);

    // back-to-back contention, write on the data side
    for (int k = 0; k < 4; k++) begin
      inst_req = 1; inst_addr = 32'hBFC00010 + k;
      data_req = 1; data_wr = 1; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
      data_size = 2'b10;
      addr_ok = 1; data_ok = 0; step(acc);
      if (acc == 1) inst_req = 0;
      if (acc == 2) data_req = 0;
      addr_ok = 0; step(acc);
      data_ok = 1; rdata = 32'hA5A50000 + k; step(acc);
      data_ok = 0;
    end
    zero_inputs(); step(acc);

    // grant lock held against a rising competitor, then released by a drop
    data_req = 1; data_wr = 1; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF; step(acc);
    inst_req = 1; inst_addr = 32'hBFC00100;
    for (int k = 0; k < 3; k++) step(acc);
    data_req = 0; addr_ok = 1; step(acc);

    // hold-off of data during WAIT_I, data served right after
    addr_ok = 0; inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h80002000;
    step(acc); step(acc);
    data_ok = 1; rdata = 32'h0BADF00D; step(acc);
    data_ok = 0; addr_ok = 1; step(acc);

    // reset while waiting on data, late data_ok ignored, then a normal inst read
    zero_inputs(); rst = 0; step(acc);
    rst = 1; data_ok = 1; rdata = 32'hFFFFFFFF; step(acc);
    data_ok = 0; inst_req = 1; inst_addr = 32'hBFC00200; addr_ok = 1; step(acc);
    zero_inputs(); data_ok = 1; rdata = 32'h00C0FFEE; step(acc);
    zero_inputs(); step(acc);

    i_act = 0; d_act = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_act && $urandom_range(3) == 0) begin
        i_act = 1; inst_addr = $urandom; inst_wdata = $urandom;
        inst_wr = 1'($urandom_range(1)); inst_size = 2'($urandom_range(3));
      end else if (i_act && $urandom_range(15) == 0) begin
        i_act = 0;
      end
      if (!d_act && $urandom_range(3) == 0) begin
        d_act = 1; data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom_range(1)); data_size = 2'($urandom_range(3));
      end else if (d_act && $urandom_range(15) == 0) begin
        d_act = 0;
      end
      inst_req = i_act;
      data_req = d_act;
      addr_ok  = 1'($urandom_range(1));
      data_ok  = ($urandom_range(2) == 0);
      rdata    = $urandom;
      rst      = ($urandom_range(60) != 0);
      step(acc);
      if (acc == 1) i_act = 0;
      if (acc == 2) d_act = 0;
    end

    zero_inputs(); rst = 1;
    step(acc);
    @(negedge clk); #1;
    chk("cyc_q_drained", cyc_q.size(), 32'h0);
    chk("rsp_q_drained", rsp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-low (rst==0 resets on posedge clk).
REQ-003 inst_req/inst_wr/inst_size[1:0]/inst_addr[31:0]/inst_wdata[31:0]  in  instruction-side sram-like master request.
REQ-004 inst_rdata[31:0]/inst_addr_ok/inst_data_ok  out  instruction-side responses.
REQ-005 data_req/data_wr/data_size[1:0]/data_addr[31:0]/data_wdata[31:0]  in  data-side sram-like master request.
REQ-006 data_rdata[31:0]/data_addr_ok/data_data_ok  out  data-side responses.
REQ-007 req/wr/size[1:0]/addr[31:0]/wdata[31:0]  out  merged sram-like slave request.
REQ-008 rdata[31:0]/addr_ok/data_ok  in  slave responses.

Function
REQ-009 FSM states SHALL be IDLE, WAIT_I, WAIT_D; at most one transaction outstanding.
REQ-010 In IDLE, arbitration SHALL pick a grant: with exactly one master requesting, that master; with both, per REQ-024/025.
REQ-011 Grant lock: once req is driven for a master in IDLE without addr_ok, the grant SHALL be held on following cycles while that master keeps its req high; if it drops req before addr_ok, the lock clears and arbitration restarts the same cycle.
REQ-012 In IDLE, req SHALL equal the granted master's req; wr/size/addr/wdata SHALL combinationally mirror the granted master (zero when none granted).
REQ-013 Slave addr_ok in IDLE with a grant SHALL assert only the granted master's *_addr_ok the same cycle (0-cycle forward), and the FSM SHALL move to WAIT_I or WAIT_D on the next edge.
REQ-014 In WAIT_I/WAIT_D, req SHALL be 0 and both *_addr_ok SHALL be 0.
REQ-015 In WAIT_x, slave data_ok SHALL assert x_data_ok the same cycle and drive x_rdata=rdata; the FSM returns to IDLE on the next edge; no new request is issued in the data_ok cycle.
REQ-016 *_rdata SHALL be rdata for the owning master when its data_ok is high, else 32'h0.
REQ-017 data_ok received in IDLE SHALL be ignored (no master data_ok); addr_ok received in WAIT_x SHALL be ignored.
REQ-018 A master's response SHALL never be forwarded to the other master.
REQ-019 New request from the non-owning master during WAIT_x SHALL be held off (no addr_ok) until IDLE.

Reset
REQ-020 rst==0 SHALL force IDLE, clear grant lock, and clear the round-robin pointer (REQ-025) to "data last served".
REQ-021 During and after reset until a grant exists, req, wr, *_addr_ok, *_data_ok SHALL be 0; size=2'b00, addr/wdata/*_rdata=32'h0.
REQ-022 Reset asserted while in WAIT_x SHALL abandon the transaction; a later data_ok SHALL be ignored per REQ-017.
REQ-023 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-024 Without ARB_ROUND_ROBIN_EN: fixed priority, data wins every contested IDLE arbitration.
REQ-025 With ARB_ROUND_ROBIN_EN: a 1-bit last-served pointer updates on each slave addr_ok; on contention the master not last served wins; non-contested arbitration unaffected.

Verification
REQ-026 Single inst read: inst_req=1 addr=32'hBFC00000, slave addr_ok same cycle, data_ok 2 cycles later rdata=32'h3C080001 -> inst_addr_ok cycle 0, inst_data_ok+inst_rdata=32'h3C080001 cycle 2, data_* outputs 0 throughout.
REQ-027 Contention: inst_req and data_req (wr=1, addr=32'h80001000, wdata=32'hDEADBEEF) both high in IDLE -> macro off: data granted first, inst after data_data_ok; macro on, reset pointer: inst first, then data, then alternates on back-to-back contention.
REQ-028 Grant lock: data granted, slave withholds addr_ok 3 cycles while inst_req rises -> addr stays 32'h80001000 all 3 cycles; data drops req before addr_ok -> inst granted the same cycle.
REQ-029 Hold-off: in WAIT_I, data_req=1 -> req=0, data_addr_ok=0 until inst_data_ok cycle; data granted the following cycle.
REQ-030 Reset mid-op: rst=0 during WAIT_D, then slave data_ok=1 after release -> data_data_ok and inst_data_ok stay 0, FSM IDLE, next inst_req served normally.
